// File: rtl/instr_word_encoder.sv
// Instruction-word encoder: packs micro-op descriptors into 32-bit words and writes them into IMEM.
// Build option: define RD15_GUARD_EN to reject DP/LDR descriptors that target rd=15.
module instr_word_encoder #(
  parameter int unsigned ADDR_W = 10,
  parameter logic [3:0]  COND   = 4'hE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [2:0]        in_alu,
  input  logic              in_s,
  input  logic [3:0]        in_rn,
  input  logic [3:0]        in_rd,
  input  logic [3:0]        in_rm,
  input  logic [11:0]       in_imm,
  input  logic [ADDR_W-1:0] in_target,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_wready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] count
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned OFF_W  = 24;
  localparam int unsigned DIFF_W = ADDR_W + 1;

  localparam logic [2:0] KIND_DP_REG = 3'd0;
  localparam logic [2:0] KIND_DP_IMM = 3'd1;
  localparam logic [2:0] KIND_LDR    = 3'd2;
  localparam logic [2:0] KIND_STR    = 3'd3;
  localparam logic [2:0] KIND_B      = 3'd4;
  localparam logic [2:0] KIND_HALT   = 3'd5;

  localparam logic [1:0]  OP_DP      = 2'b00;
  localparam logic [1:0]  OP_MEM     = 2'b01;
  localparam logic [1:0]  OP_BR      = 2'b10;
  localparam logic [5:0]  FUNCT_LDR  = 6'b011001;
  localparam logic [5:0]  FUNCT_STR  = 6'b011000;
  localparam logic [1:0]  BR_FUNCT   = 2'b10;
  localparam logic [27:0] HALT_BODY  = 28'hDA00000;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCEPT = 2'd1,
    S_WRITE  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic              halt_q;
  logic [3:0]        cmd_c;
  logic [DIFF_W-1:0] br_diff_c;
  logic [OFF_W-1:0]  br_off_c;
  logic [WORD_W-1:0] word_c;
  logic              halt_c;
  logic              reject_c;
  logic              accept_c;
  logic              wrote_c;
  logic              start_c;
  logic              in_ready_d;
  logic              mem_we_d;
  logic              busy_d;
  logic              done_d;

  assign accept_c = (state_q == S_ACCEPT) && in_valid;
  assign wrote_c  = (state_q == S_WRITE) && mem_wready;
  assign start_c  = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  // ALU selector to the 4-bit cmd field of data-processing words
  always_comb begin
    cmd_c = 4'b0100;
    case (in_alu)
      3'd0:    cmd_c = 4'b0100;
      3'd1:    cmd_c = 4'b0010;
      3'd2:    cmd_c = 4'b0000;
      3'd3:    cmd_c = 4'b1100;
      3'd4:    cmd_c = 4'b0001;
      3'd5:    cmd_c = 4'b0011;
      3'd6:    cmd_c = 4'b0101;
      default: cmd_c = 4'b0111;
    endcase
  end

  // Branch offset is relative to PC+8, i.e. two words past the write address
  always_comb begin
    br_diff_c = {1'b0, in_target} - ({1'b0, mem_addr} + DIFF_W'(2));
    br_off_c  = OFF_W'($signed(br_diff_c));
  end

  // Word packing and rejection of descriptors that must not be written
  always_comb begin
    word_c   = '0;
    halt_c   = 1'b0;
    reject_c = 1'b0;
    case (in_kind)
      KIND_DP_REG: word_c = {COND, OP_DP, 1'b0, cmd_c, in_s, in_rn, in_rd, 8'h00, in_rm};
      KIND_DP_IMM: word_c = {COND, OP_DP, 1'b1, cmd_c, in_s, in_rn, in_rd, in_imm};
      KIND_LDR:    word_c = {COND, OP_MEM, FUNCT_LDR, in_rn, in_rd, in_imm};
      KIND_STR:    word_c = {COND, OP_MEM, FUNCT_STR, in_rn, in_rd, in_imm};
      KIND_B:      word_c = {COND, OP_BR, BR_FUNCT, br_off_c};
      KIND_HALT: begin
        word_c = {COND, HALT_BODY};
        halt_c = 1'b1;
      end
      default:     reject_c = 1'b1;
    endcase
`ifdef RD15_GUARD_EN
    if (((in_kind == KIND_DP_REG) || (in_kind == KIND_DP_IMM) || (in_kind == KIND_LDR)) &&
        (in_rd == 4'hF)) begin
      reject_c = 1'b1;
    end
`endif
  end

  // State register with registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      in_ready <= 1'b0;
      mem_we   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      in_ready <= in_ready_d;
      mem_we   <= mem_we_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_ACCEPT;
      S_ACCEPT: if (in_valid && !reject_c) state_d = S_WRITE;
      S_WRITE:  if (mem_wready) state_d = halt_q ? S_DONE : S_ACCEPT;
      S_DONE:   if (start) state_d = S_ACCEPT;
      default:  state_d = S_IDLE;
    endcase
  end

  // Status outputs decoded from the upcoming state so they register in step with it
  always_comb begin
    in_ready_d = 1'b0;
    mem_we_d   = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    case (state_d)
      S_ACCEPT: begin
        in_ready_d = 1'b1;
        busy_d     = 1'b1;
      end
      S_WRITE: begin
        mem_we_d = 1'b1;
        busy_d   = 1'b1;
      end
      S_DONE:   done_d = 1'b1;
      default:  ;
    endcase
  end

  // Address, count, pending word and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      count     <= '0;
      err       <= 1'b0;
      halt_q    <= 1'b0;
    end else begin
      if (start_c) begin
        mem_addr <= base_addr;
        count    <= '0;
        err      <= 1'b0;
      end
      if (accept_c) begin
        if (reject_c) begin
          err <= 1'b1;
        end else begin
          mem_wdata <= word_c;
          halt_q    <= halt_c;
        end
      end
      if (wrote_c) begin
        mem_addr <= mem_addr + ADDR_W'(1);
        count    <= count + ADDR_W'(1);
        if (&mem_addr) err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_word_encoder.sv
// Scoreboard bench for instr_word_encoder: stimulus pushes expected IMEM writes, a monitor pops and compares.
module tb_instr_word_encoder;

  localparam int unsigned AW    = 10;
  localparam int unsigned DEPTH = 1 << AW;

  typedef struct {
    logic [2:0]    kind;
    logic [2:0]    alu;
    logic          s;
    logic [3:0]    rn;
    logic [3:0]    rd;
    logic [3:0]    rm;
    logic [11:0]   imm;
    logic [AW-1:0] target;
  } desc_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_kind;
  logic [2:0]    in_alu;
  logic          in_s;
  logic [3:0]    in_rn;
  logic [3:0]    in_rd;
  logic [3:0]    in_rm;
  logic [11:0]   in_imm;
  logic [AW-1:0] in_target;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_wready;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW-1:0] count;

  instr_word_encoder dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind), .in_alu(in_alu),
    .in_s(in_s), .in_rn(in_rn), .in_rd(in_rd), .in_rm(in_rm), .in_imm(in_imm),
    .in_target(in_target), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wready(mem_wready), .busy(busy), .done(done), .err(err), .count(count)
  );

  int n_vec;
  int n_err;
  int wr_mode;
  exp_t sb[$];

  int unsigned m_addr;
  int unsigned m_count;
  bit m_err;
  bit m_done;
  bit m_active;

  logic          stalled;
  logic [AW-1:0] h_addr;
  logic [31:0]   h_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic desc_t mk(input int k, input int a, input int s, input int rn, input int rd,
                               input int rm, input int imm, input int tgt);
    desc_t d;
    d.kind = 3'(k); d.alu = 3'(a); d.s = 1'(s); d.rn = 4'(rn); d.rd = 4'(rd);
    d.rm = 4'(rm); d.imm = 12'(imm); d.target = AW'(tgt);
    return d;
  endfunction

  function automatic bit rejected(input desc_t d);
    bit r;
    r = (d.kind > 3'd5);
`ifdef RD15_GUARD_EN
    if (d.kind <= 3'd2 && d.rd == 4'hF) r = 1'b1;
`endif
    return r;
  endfunction

  // Reference encoder: field values placed by shift arithmetic
  function automatic logic [31:0] ref_word(input desc_t d, input int unsigned waddr);
    int cmdtab [8] = '{4, 2, 0, 12, 1, 3, 5, 7};
    int off;
    logic [31:0] w;
    w = 32'hE000_0000;
    case (d.kind)
      3'd0: w = w | (32'(cmdtab[d.alu] * 2 + int'(d.s)) << 20) | (32'(d.rn) << 16)
                  | (32'(d.rd) << 12) | 32'(d.rm);
      3'd1: w = w | (32'(32 + cmdtab[d.alu] * 2 + int'(d.s)) << 20) | (32'(d.rn) << 16)
                  | (32'(d.rd) << 12) | 32'(d.imm);
      3'd2: w = w | (32'(1) << 26) | (32'(25) << 20) | (32'(d.rn) << 16)
                  | (32'(d.rd) << 12) | 32'(d.imm);
      3'd3: w = w | (32'(1) << 26) | (32'(24) << 20) | (32'(d.rn) << 16)
                  | (32'(d.rd) << 12) | 32'(d.imm);
      3'd4: begin
        off = int'(d.target) - int'(waddr) - 2;
        off = ((off % int'(2 * DEPTH)) + int'(2 * DEPTH)) % int'(2 * DEPTH);
        if (off >= int'(DEPTH)) off = off - int'(2 * DEPTH);
        w = w | (32'(2) << 26) | (32'(2) << 24) | (32'(off) & 32'h00FF_FFFF);
      end
      3'd5: w = 32'hEDA0_0000;
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  task automatic do_start(input int unsigned b);
    @(posedge clk); #1;
    start = 1'b1; base_addr = AW'(b);
    @(posedge clk); #1;
    start = 1'b0;
    if (!m_active) begin
      m_addr = b; m_count = 0; m_err = 1'b0; m_done = 1'b0; m_active = 1'b1;
    end
  endtask

  task automatic send(input desc_t d, input bit use_exp, input logic [31:0] exp_word);
    int t;
    exp_t e;
    t = 0;
    while (in_ready !== 1'b1 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (in_ready !== 1'b1) begin
      chk("send_wait_ready", 32'(in_ready), 32'd1);
      return;
    end
    in_kind = d.kind; in_alu = d.alu; in_s = d.s; in_rn = d.rn; in_rd = d.rd;
    in_rm = d.rm; in_imm = d.imm; in_target = d.target; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (rejected(d)) begin
      m_err = 1'b1;
    end else begin
      e.addr = AW'(m_addr);
      e.data = use_exp ? exp_word : ref_word(d, m_addr);
      sb.push_back(e);
      if (m_addr == DEPTH - 1) m_err = 1'b1;
      m_addr  = (m_addr + 1) % DEPTH;
      m_count = (m_count + 1) % DEPTH;
      if (d.kind == 3'd5) begin
        m_active = 1'b0; m_done = 1'b1;
      end
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while (!(((in_ready === 1'b1) || (done === 1'b1)) && (mem_we === 1'b0)) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) begin
      n_vec++; n_err++;
      $display("FAIL idle_wait: timed out with in_ready=%b done=%b mem_we=%b", in_ready, done, mem_we);
    end
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_count"}, 32'(count), m_count);
    chk({tag, "_err"}, 32'(err), 32'(m_err));
    chk({tag, "_done"}, 32'(done), 32'(m_done));
    chk({tag, "_busy"}, 32'(busy), 32'(m_active));
    chk({tag, "_in_ready"}, 32'(in_ready), 32'(m_active));
    chk({tag, "_mem_addr"}, 32'(mem_addr), m_addr);
    chk({tag, "_sb_drained"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_count"}, 32'(count), 32'd0);
  endtask

  // IMEM ready: 0 always ready, 1 random backpressure, 2 held off
  initial begin
    mem_wready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (wr_mode)
        0:       mem_wready = 1'b1;
        1:       mem_wready = ($urandom_range(0, 3) != 0);
        default: mem_wready = 1'b0;
      endcase
    end
  end

  // Monitor: completed writes against the scoreboard, stalled writes must hold steady
  initial begin
    exp_t e;
    stalled = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          chk("stall_mem_we", 32'(mem_we), 32'd1);
          chk("stall_mem_addr", 32'(mem_addr), 32'(h_addr));
          chk("stall_mem_wdata", mem_wdata, h_data);
        end
        if (mem_we === 1'b1) begin
          chk("write_in_ready_low", 32'(in_ready), 32'd0);
          if (mem_wready) begin
            if (sb.size() == 0) begin
              n_vec++; n_err++;
              $display("FAIL unexpected_write: addr %h data %h, no write expected", mem_addr, mem_wdata);
            end else begin
              e = sb.pop_front();
              chk("write_addr", 32'(mem_addr), 32'(e.addr));
              chk("write_data", mem_wdata, e.data);
            end
            stalled = 1'b0;
          end else begin
            stalled = 1'b1; h_addr = mem_addr; h_data = mem_wdata;
          end
        end else begin
          stalled = 1'b0;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    desc_t d;
    n_vec = 0; n_err = 0; wr_mode = 0;
    rst = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0;
    in_kind = '0; in_alu = '0; in_s = 1'b0; in_rn = '0; in_rd = '0; in_rm = '0;
    in_imm = '0; in_target = '0;
    m_addr = 0; m_count = 0; m_err = 1'b0; m_done = 1'b0; m_active = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed sequence from base 0
    do_start(0);
    send(mk(0, 0, 0, 2, 1, 3, 0, 0), 1'b1, 32'hE082_1003);
    wait_idle();
    chk("count_after_first", 32'(count), 32'd1);
    check_quiet("seq1_a");
    do_start(100);
    send(mk(1, 1, 1, 4, 4, 0, 5, 0), 1'b1, 32'hE254_4005);
    send(mk(2, 0, 0, 1, 0, 0, 8, 0), 1'b1, 32'hE591_0008);
    send(mk(3, 0, 1, 1, 0, 0, 8, 0), 1'b1, 32'hE581_0008);
    wait_idle();
    check_quiet("seq1_b");

    // IMEM back-pressure for three cycles
    wr_mode = 2;
    send(mk(0, 3, 1, 5, 6, 7, 0, 0), 1'b0, 32'h0);
    repeat (3) begin
      @(negedge clk);
      chk("stall3_mem_we", 32'(mem_we), 32'd1);
      chk("stall3_in_ready", 32'(in_ready), 32'd0);
    end
    wr_mode = 0;
    wait_idle();
    check_quiet("stall");

    // HALT parks the block; descriptors are then ignored
    send(mk(5, 0, 0, 0, 0, 0, 0, 0), 1'b1, 32'hEDA0_0000);
    wait_idle();
    check_quiet("halt1");
    @(posedge clk); #1;
    in_kind = 3'd0; in_rd = 4'd1; in_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("done_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    wait_idle();
    check_quiet("done_ignore");

    // Branch, illegal kind, rd=15
    do_start(4);
    send(mk(4, 0, 0, 0, 0, 0, 0, 2), 1'b1, 32'hEAFF_FFFC);
    send(mk(7, 0, 0, 1, 1, 1, 1, 0), 1'b0, 32'h0);
    wait_idle();
    chk("illegal_err", 32'(err), 32'd1);
    chk("illegal_count", 32'(count), 32'd1);
    send(mk(0, 0, 0, 2, 15, 3, 0, 0), 1'b1, 32'hE082_F003);
    wait_idle();
    check_quiet("rd15");
    send(mk(5, 0, 0, 0, 0, 0, 0, 0), 1'b1, 32'hEDA0_0000);
    wait_idle();
    check_quiet("halt2");

    // Random descriptors across the address wrap, random back-pressure
    do_start(1000);
    wr_mode = 1;
    for (int i = 0; i < 60; i++) begin
      d = mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1),
             $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
             $urandom_range(0, 4095), $urandom_range(0, DEPTH - 1));
      if (d.kind == 3'd5) d.kind = 3'd4;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      send(d, 1'b0, 32'h0);
    end
    send(mk(5, 0, 0, 0, 0, 0, 0, 0), 1'b0, 32'h0);
    wait_idle();
    check_quiet("random");
    wr_mode = 0;

    // Reset during a stalled write drops it
    do_start(7);
    wr_mode = 2;
    send(mk(1, 2, 0, 3, 3, 0, 9, 0), 1'b0, 32'h0);
    @(negedge clk);
    chk("rst_pre_mem_we", 32'(mem_we), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_zero("rst_mid_write");
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    m_addr = 0; m_count = 0; m_err = 1'b0; m_done = 1'b0; m_active = 1'b0;
    wr_mode = 0;
    repeat (5) @(negedge clk);
    check_quiet("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_word_encoder.md
Name: instr_word_encoder

Overview:
- Encoder for the pipelined core's ISA: the inverse of the decode-stage control unit.
- Accepts one micro-op descriptor per handshake, packs it into a 32-bit instruction word and writes it to instruction memory at an auto-incrementing address.
- Used by the program-loader path to build images in IMEM before the core is released.
- A HALT micro-op ends the sequence: it writes the stuck word and parks the block until the next start.

Parameters:
- ADDR_W, 10, instruction-memory word-address width.
- COND, 4'hE, condition field placed in bits [31:28] of every word.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse; latches base_addr and begins a sequence.
- base_addr  input  ADDR_W  first IMEM word address.
- in_valid  input  1  descriptor valid.
- in_ready  output  1  encoder can accept a descriptor.
- in_kind  input  3  0 DP_REG, 1 DP_IMM, 2 LDR, 3 STR, 4 B, 5 HALT; 6–7 illegal.
- in_alu  input  3  0 ADD, 1 SUB, 2 AND, 3 ORR, 4 MUL, 5 AVG, 6 THR, 7 SHL.
- in_s  input  1  set-flags bit (DP only).
- in_rn, in_rd, in_rm  input  4 each  register fields.
- in_imm  input  12  immediate or memory offset.
- in_target  input  ADDR_W  absolute branch-target word address.
- mem_we  output  1  IMEM write strobe.
- mem_addr  output  ADDR_W  IMEM word address.
- mem_wdata  output  32  encoded word.
- mem_wready  input  1  IMEM accepts the write this cycle.
- busy  output  1  sequence in progress.
- done  output  1  HALT word written; sticky until start or rst.
- err  output  1  sticky error flag; cleared by start or rst.
- count  output  ADDR_W  words written in the current sequence.

Behaviour:
- Reset: all outputs 0; state IDLE; address and count 0.
- FSM states: IDLE, ACCEPT, WRITE, DONE.
- IDLE: in_ready=0. On start, latch base_addr, clear err, done and count, then go to ACCEPT.
- ACCEPT: in_ready=1. On in_valid&in_ready, register the encoded word and go to WRITE.
- WRITE: mem_we=1 starting the cycle after the accept. mem_addr/mem_wdata are held stable until mem_wready. On mem_wready: addr+1, count+1, then go to ACCEPT, or to DONE if the word was HALT.
  - Throughput is at most one word per 2 cycles; there is no skid buffer.
- DONE: done=1, in_ready=0. start re-arms the sequence.
- busy = state is ACCEPT or WRITE.
- start while busy is ignored.
- rst takes effect in any state, including mid-WRITE; the pending write is dropped.
- Word layout: [31:28]=COND, [27:26]=Op, [25:20]=Funct, [19:16]=Rn, [15:12]=Rd, [11:0]=Src2.
- DP_REG: Op=00, Funct={0,cmd,S}, Src2={8'b0,rm}.
- DP_IMM: Op=00, Funct={1,cmd,S}, Src2=imm.
- cmd mapping: ADD 0100, SUB 0010, AND 0000, ORR 1100, MUL 0001, AVG 0011, THR 0101, SHL 0111.
- LDR: Op=01, Funct=011001, Src2=imm. STR: Op=01, Funct=011000, Src2=imm. S is ignored for both.
- B: Op=10, [25:24]=10, [23:0]=imm24.
  - imm24 = sign-extended (in_target − (write_addr + 2)), i.e. the PC+8 convention in words.
  - Computed at ADDR_W+1 bits signed, then sign-extended to 24.
- HALT: fixed word {COND, 28'hDA00000}, i.e. 0xEDA00000 with the default COND.
- Illegal kind (6–7): descriptor accepted, nothing written, err set; stay in ACCEPT.
- Address wrap: if a write lands at address 2^ADDR_W−1, the next address wraps to 0 and err is set. Writing continues.

Optional Feature:
- Macro RD15_GUARD_EN.
- When defined: DP_REG, DP_IMM or LDR with rd=4'hF is rejected. The descriptor is accepted, nothing is written, and err is set. This prevents unintended PC writes at decode.
- When undefined: rd=15 is encoded normally.

Test Plan:
- start base=0; DP_REG ADD rd1 rn2 rm3 S=0 -> mem_we at addr 0, wdata 0xE0821003, count=1.
- DP_IMM SUB rd4 rn4 imm5 S=1 -> wdata 0xE2544005.
- LDR rd0 rn1 imm8, then STR with the same fields -> 0xE5910008, then 0xE5810008 at consecutive addresses.
- Base 4, B target 2 -> wdata 0xEAFFFFFC at addr 4.
- mem_wready held low 3 cycles -> mem_we, mem_addr and mem_wdata stable throughout; in_ready=0 for those 3 cycles.
- HALT -> 0xEDA00000, then done=1, in_ready=0, and further in_valid is ignored until start.
- Illegal kind 7, then rd=15 ADD -> err=1 with no write. The rd=15 ADD is rejected only with RD15_GUARD_EN defined; otherwise it writes 0xE08xF00x.
- rst asserted mid-WRITE -> next cycle all outputs 0, state IDLE.
